axi_hp_rd_responder: RTL and testbench

AXI3 read-channel responder (slave) for the 32-bit HP port protocol that the AXI2S stream engine drives as initiator. It answers AR/R traffic from a local block-RAM image that is preloaded through a simple write port. It lets the TX path (AXI2S reading samples for Sout) be exercised and run standalone, in place of the PS DDR controller.

---
 rtl/axi_hp_rd_responder.sv | 152 +++++++++++++++
 tb/tb_axi_hp_rd_responder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_hp_rd_responder.sv
// AXI3 read-channel responder answering AR/R bursts from a preloadable block-RAM image.
// Two-deep AR FIFO feeds an IDLE/WAIT/BEAT read engine with a registered, stall-stable R channel.
module axi_hp_rd_responder #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned RD_LAT = 0,
  parameter int unsigned ID_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   AXI_arid,
  input  logic [31:0]       AXI_araddr,
  input  logic [3:0]        AXI_arlen,
  input  logic [2:0]        AXI_arsize,
  input  logic [1:0]        AXI_arburst,
  input  logic              AXI_arvalid,
  output logic              AXI_arready,
  output logic [ID_W-1:0]   AXI_rid,
  output logic [31:0]       AXI_rdata,
  output logic [1:0]        AXI_rresp,
  output logic              AXI_rlast,
  output logic              AXI_rvalid,
  input  logic              AXI_rready,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data
);

  localparam int unsigned DEPTH    = 2 ** ADDR_W;
  localparam logic [3:0]  LAT_LAST = 4'((RD_LAT > 0) ? RD_LAT - 1 : 0);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        len;
    logic [1:0]        burst;
    logic              err;
  } ar_entry_t;

  typedef enum logic [1:0] {IDLE, WAIT, BEAT} state_t;

  state_t            state, state_d;
  ar_entry_t         fifo_q [2];
  ar_entry_t         cur;
  ar_entry_t         entry_c;
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count, count_c;
  logic [3:0]        beat, lat_cnt;
  logic              push_c, pop_c, load_c, done_c;
  logic [31:0]       mem [DEPTH];
  logic              unused_c;

  assign unused_c = ^AXI_araddr[31:ADDR_W+2];

  // AR capture and FIFO occupancy after this edge
  always_comb begin
    entry_c.id    = AXI_arid;
    entry_c.addr  = AXI_araddr[ADDR_W+1:2];
    entry_c.len   = AXI_arlen;
    entry_c.burst = AXI_arburst;
    entry_c.err   = (AXI_arsize != 3'b010) || (AXI_araddr[1:0] != 2'b00);
    push_c        = AXI_arvalid & AXI_arready;
    count_c       = count;
    if (push_c && !pop_c)      count_c = count + 2'd1;
    else if (!push_c && pop_c) count_c = count - 2'd1;
  end

  // read engine next-state
  always_comb begin
    state_d = state;
    pop_c   = 1'b0;
    load_c  = 1'b0;
    done_c  = 1'b0;
    unique case (state)
      IDLE: if (count != 2'd0) begin
        pop_c   = 1'b1;
        state_d = (RD_LAT == 0) ? BEAT : WAIT;
      end
      WAIT: if (lat_cnt == LAT_LAST) state_d = BEAT;
      BEAT: begin
        if (!AXI_rvalid) begin
          load_c = 1'b1;
        end else if (AXI_rready) begin
          if (AXI_rlast) begin
            done_c  = 1'b1;
            state_d = IDLE;
          end else begin
            load_c = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // storage without reset: memory image survives reset
  always_ff @(posedge clk) begin
    if (ld_we)  mem[ld_addr] <= ld_data;
    if (push_c) fifo_q[wr_ptr] <= entry_c;
    if (pop_c) begin
      cur <= fifo_q[rd_ptr];
    end else if (load_c && (cur.burst != 2'b00)) begin
      cur.addr <= cur.addr + ADDR_W'(1);
    end
  end

  // FIFO pointers, latency counter and R channel registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      AXI_arready <= 1'b0;
      beat        <= 4'd0;
      lat_cnt     <= 4'd0;
      AXI_rvalid  <= 1'b0;
      AXI_rlast   <= 1'b0;
      AXI_rid     <= '0;
      AXI_rdata   <= 32'd0;
      AXI_rresp   <= 2'b00;
    end else begin
      count       <= count_c;
      AXI_arready <= (count_c != 2'd2);
      if (push_c) wr_ptr <= ~wr_ptr;
      if (pop_c) begin
        rd_ptr  <= ~rd_ptr;
        beat    <= 4'd0;
        lat_cnt <= 4'd0;
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt + 4'd1;
      end
      // synchronous read straight into the output register; only advances on a free slot
      if (load_c) begin
        AXI_rdata  <= cur.err ? 32'd0 : mem[cur.addr];
        AXI_rid    <= cur.id;
        AXI_rresp  <= cur.err ? 2'b10 : 2'b00;
        AXI_rlast  <= (beat == cur.len);
        AXI_rvalid <= 1'b1;
        beat       <= beat + 4'd1;
      end
      if (done_c) begin
        AXI_rvalid <= 1'b0;
        AXI_rlast  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_hp_rd_responder.sv
// Self-checking bench for axi_hp_rd_responder: vector table plus scoreboard of expected R beats.
// Hand sequences cover FIFO back-pressure and reset in the middle of a burst.
module tb_axi_hp_rd_responder;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned ID_W   = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic [ID_W-1:0]   arid;
  logic [31:0]       araddr;
  logic [3:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready = 1'b0;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;

  typedef struct {
    logic [31:0]     data;
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
    logic            last;
  } beat_t;

  typedef struct {
    logic [31:0]     addr;
    logic [3:0]      len;
    logic [2:0]      size;
    logic [1:0]      burst;
    logic [ID_W-1:0] id;
    int              mode;
    logic [1:0]      exp_resp;
  } vec_t;

  beat_t       sb[$];
  vec_t        vecs[8];
  logic [31:0] tb_mem [2**ADDR_W];
  int          n_vec = 0;
  int          n_err = 0;
  int          hs_cnt = 0;
  int          rr_mode = 0;

  axi_hp_rd_responder #(.ADDR_W(ADDR_W), .RD_LAT(0), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .AXI_arid(arid), .AXI_araddr(araddr), .AXI_arlen(arlen), .AXI_arsize(arsize),
    .AXI_arburst(arburst), .AXI_arvalid(arvalid), .AXI_arready(arready),
    .AXI_rid(rid), .AXI_rdata(rdata), .AXI_rresp(rresp), .AXI_rlast(rlast),
    .AXI_rvalid(rvalid), .AXI_rready(rready),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  always #5 clk = ~clk;

  // rready pattern: 0 always high, 1 toggling, otherwise held low
  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       rready = 1'b1;
      1:       rready = ~rready;
      default: rready = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // R-channel monitor: scoreboard pop, stall stability and inter-burst gap
  logic            hold_pending = 1'b0;
  logic            prev_last_hs = 1'b0;
  logic [40+ID_W:0] hold_val;
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      hold_pending = 1'b0;
      prev_last_hs = 1'b0;
    end else begin
      if (prev_last_hs) chk("gap_rvalid", 64'(rvalid), 64'(0));
      if (hold_pending && rvalid) chk("hold_stable", 64'({rdata, rid, rresp, rlast}), 64'(hold_val));
      hold_pending = 1'b0;
      prev_last_hs = 1'b0;
      if (rvalid && rready) begin
        hs_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_beat", 64'(rdata), 64'hDEAD_BEEF_0000_0000);
        end else begin
          e = sb.pop_front();
          chk("rdata", 64'(rdata), 64'(e.data));
          chk("rid",   64'(rid),   64'(e.id));
          chk("rresp", 64'(rresp), 64'(e.resp));
          chk("rlast", 64'(rlast), 64'(e.last));
          prev_last_hs = rlast;
        end
      end else if (rvalid) begin
        hold_pending = 1'b1;
        hold_val     = {rdata, rid, rresp, rlast};
      end
    end
  end

  task automatic expect_burst(input vec_t v);
    beat_t             e;
    logic [ADDR_W-1:0] wa;
    for (int b = 0; b <= int'(v.len); b++) begin
      wa     = v.addr[ADDR_W+1:2] + ADDR_W'((v.burst == 2'b00) ? 0 : b);
      e.data = (v.exp_resp == 2'b10) ? 32'd0 : tb_mem[wa];
      e.id   = v.id;
      e.resp = v.exp_resp;
      e.last = (b == int'(v.len));
      sb.push_back(e);
    end
  endtask

  task automatic set_ar(input vec_t v);
    arid    = v.id;
    araddr  = v.addr;
    arlen   = v.len;
    arsize  = v.size;
    arburst = v.burst;
    arvalid = 1'b1;
  endtask

  // returns 1ns after the handshake edge
  task automatic send_ar(input vec_t v);
    logic ok;
    ok = 1'b0;
    set_ar(v);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (arready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ar_accept", 64'(ok), 64'(1));
    @(posedge clk);
    #1 arvalid = 1'b0;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0 && !rvalid) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain", 64'(done), 64'(1));
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    ld_we   = 1'b1;
    ld_addr = a;
    ld_data = d;
    tb_mem[a] = d;
    @(posedge clk);
    #1 ld_we = 1'b0;
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s,
                              input logic [1:0] bu, input logic [ID_W-1:0] id, input int m,
                              input logic [1:0] er);
    vec_t v;
    v.addr = a; v.len = l; v.size = s; v.burst = bu; v.id = id; v.mode = m; v.exp_resp = er;
    return v;
  endfunction

  initial begin
    int   c0;
    logic seen;
    vec_t v;
    rst = 1'b1; arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;

    vecs[0] = mk(32'h0040, 4'd3,  3'b010, 2'b01, 6'd5,  0, 2'b00);
    vecs[1] = mk(32'h0040, 4'd3,  3'b010, 2'b01, 6'd5,  1, 2'b00);
    vecs[2] = mk(32'h3FF8, 4'd3,  3'b010, 2'b01, 6'd9,  0, 2'b00);
    vecs[3] = mk(32'h0020, 4'd3,  3'b010, 2'b00, 6'd12, 0, 2'b00);
    vecs[4] = mk(32'h0020, 4'd2,  3'b001, 2'b01, 6'd13, 0, 2'b10);
    vecs[5] = mk(32'h0000, 4'd15, 3'b010, 2'b10, 6'd63, 1, 2'b00);
    vecs[6] = mk(32'h0042, 4'd0,  3'b010, 2'b01, 6'd1,  0, 2'b10);
    vecs[7] = mk(32'h007C, 4'd1,  3'b010, 2'b00, 6'd33, 1, 2'b00);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_arready", 64'(arready), 64'(0));
    chk("rst_rvalid",  64'(rvalid),  64'(0));
    chk("rst_rlast",   64'(rlast),   64'(0));
    chk("rst_rid",     64'(rid),     64'(0));
    chk("rst_rdata",   64'(rdata),   64'(0));
    chk("rst_rresp",   64'(rresp),   64'(0));
    rst = 1'b0;
    @(posedge clk);
    #1 chk("arready_after_rst", 64'(arready), 64'(1));

    for (int i = 0; i < 32; i++) preload(ADDR_W'(i), 32'hA500_0000 + 32'(i));
    preload(12'hFFE, 32'h5A00_0FFE);
    preload(12'hFFF, 32'h5A00_0FFF);

    // table-driven bursts
    for (int i = 0; i < 8; i++) begin
      rr_mode = vecs[i].mode;
      @(posedge clk);
      #2;
      expect_burst(vecs[i]);
      send_ar(vecs[i]);
      if (i == 0) begin
        @(negedge clk);
        @(negedge clk);
        chk("lat_n1_rvalid", 64'(rvalid), 64'(0));
        @(negedge clk);
        chk("lat_n2_rvalid", 64'(rvalid), 64'(1));
      end
      drain();
    end

    // back-pressure: three ARs fill engine + FIFO, the fourth must stall
    rr_mode = 2;
    @(posedge clk);
    #2;
    for (int k = 0; k < 3; k++) begin
      v = mk(32'(k * 32), 4'd1, 3'b010, 2'b01, ID_W'(k + 1), 2, 2'b00);
      expect_burst(v);
      send_ar(v);
    end
    v = mk(32'h0060, 4'd1, 3'b010, 2'b01, 6'd4, 2, 2'b00);
    expect_burst(v);
    set_ar(v);
    repeat (3) @(negedge clk);
    chk("ar4_blocked", 64'(arready), 64'(0));
    chk("stalled_rid", 64'(rid), 64'(1));
    rr_mode = 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (arready) begin
        seen = 1'b1;
        break;
      end
    end
    chk("ar4_accept", 64'(seen), 64'(1));
    @(posedge clk);
    #1 arvalid = 1'b0;
    drain();

    // reset during beat 2 of an 8-beat burst
    v = mk(32'h0000, 4'd7, 3'b010, 2'b01, 6'd20, 0, 2'b00);
    expect_burst(v);
    c0 = hs_cnt;
    send_ar(v);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (hs_cnt >= c0 + 1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("first_beat_seen", 64'(seen), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("midrst_rvalid",  64'(rvalid),  64'(0));
    chk("midrst_arready", 64'(arready), 64'(0));
    chk("midrst_rlast",   64'(rlast),   64'(0));
    sb.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 chk("post_rst_arready", 64'(arready), 64'(1));
    repeat (3) @(negedge clk);
    chk("no_partial_rvalid", 64'(rvalid), 64'(0));
    v = mk(32'h0000, 4'd0, 3'b010, 2'b01, 6'd7, 0, 2'b00);
    expect_burst(v);
    send_ar(v);
    drain();
    chk("mem_retained", 64'(tb_mem[0]), 64'h0000_0000_A500_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
